// File: rtl/snake_control.sv
// Snake game master sequencer: RAM clear/default load, then draw/wait/move/shift/tail per frame.
// Optional `define SNAKE_PAUSE_EN adds a pause input that freezes the WAIT frame counter and key sampling.
module snake_control #(
  parameter int unsigned FRAME_CYCLES = 833333,
  parameter int unsigned MAX_LEN      = 2048,
  parameter int unsigned INIT_LEN     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] key_dir,
  input  logic       isDead,
  input  logic       inc_length,
  output logic       reset_ram,
  output logic       ld_q_def,
  output logic       ld_head,
  output logic       rst_address,
  output logic       inc_address,
  output logic       draw_q,
  output logic       draw_curr,
  output logic       food_en,
  output logic       update_head,
  output logic       check_inc,
  output logic       lock,
  output logic       ld_head_into_prev,
  output logic       ld_q_into_curr,
  output logic       ld_prev_into_q,
  output logic       ld_curr_into_prev,
  output logic [3:0] cnt_status,
  output logic [2:0] dir,
  output logic [2:0] colour,
  output logic       game_over
`ifdef SNAKE_PAUSE_EN
  ,
  input  logic       pause
`endif
);

  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned FW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [AW-1:0] ADDR_LAST  = AW'(MAX_LEN - 1);
  localparam logic [AW-1:0] INIT_LAST  = AW'(INIT_LEN - 1);
  localparam logic [AW-1:0] INIT_LEN_A = AW'(INIT_LEN);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYCLES - 1);

  typedef enum logic [4:0] {
    S_CLR, S_CLR_DONE, S_INIT, S_INIT_DONE, S_DRAW_RD, S_DRAW, S_FOOD, S_WAIT,
    S_MOVE1, S_MOVE2, S_MOVE3, S_SH_RD, S_SH1, S_SH2, S_TAIL, S_TAIL_ADV,
    S_TAIL_ADV2, S_TAIL_CLR, S_TAIL_END, S_DEAD
  } state_t;

  state_t          state, next_state;
  logic            run;
  logic [AW-1:0]   mirror;
  logic [AW-1:0]   len;
  logic [FW-1:0]   frame_cnt;
  logic            grow;
  logic            at_end;
  logic            wait_hold;
  logic [2:0]      req;
  logic            req_vld;

`ifdef SNAKE_PAUSE_EN
  assign wait_hold = pause;
`else
  assign wait_hold = 1'b0;
`endif

  // The sentinel lives at address len, so the mirror counter reaching len stands in for q[15].
  assign at_end = (mirror == len) || (mirror == ADDR_LAST);

  always_comb begin
    req     = dir;
    req_vld = 1'b0;
    if (key_dir[3]) begin
      req = 3'b100; req_vld = 1'b1;
    end else if (key_dir[2]) begin
      req = 3'b110; req_vld = 1'b1;
    end else if (key_dir[1]) begin
      req = 3'b000; req_vld = 1'b1;
    end else if (key_dir[0]) begin
      req = 3'b001; req_vld = 1'b1;
    end
  end

  always_comb begin
    next_state        = state;
    reset_ram         = 1'b0;
    ld_q_def          = 1'b0;
    ld_head           = 1'b0;
    rst_address       = 1'b0;
    inc_address       = 1'b0;
    draw_q            = 1'b0;
    draw_curr         = 1'b0;
    food_en           = 1'b0;
    update_head       = 1'b0;
    check_inc         = 1'b0;
    lock              = 1'b0;
    ld_head_into_prev = 1'b0;
    ld_q_into_curr    = 1'b0;
    ld_prev_into_q    = 1'b0;
    ld_curr_into_prev = 1'b0;
    colour            = 3'b000;
    game_over         = 1'b0;
    if (run) begin
      case (state)
        S_CLR: begin
          reset_ram   = 1'b1;
          inc_address = 1'b1;
          if (mirror == ADDR_LAST) next_state = S_CLR_DONE;
        end
        S_CLR_DONE: begin
          rst_address = 1'b1;
          next_state  = S_INIT;
        end
        S_INIT: begin
          ld_q_def    = 1'b1;
          inc_address = 1'b1;
          if (mirror == INIT_LAST) next_state = S_INIT_DONE;
        end
        S_INIT_DONE: begin
          ld_head     = 1'b1;
          rst_address = 1'b1;
          next_state  = S_DRAW_RD;
        end
        S_DRAW_RD: next_state = S_DRAW;
        S_DRAW: begin
          if (at_end) begin
            next_state = isDead ? S_DEAD : S_FOOD;
          end else begin
            draw_q = 1'b1;
            colour = 3'b010;
            if (cnt_status == 4'd15) begin
              inc_address = 1'b1;
              next_state  = S_DRAW_RD;
            end
          end
        end
        S_FOOD: begin
          food_en = 1'b1;
          colour  = 3'b100;
          if (cnt_status == 4'd15) begin
            rst_address = 1'b1;
            next_state  = S_WAIT;
          end
        end
        S_WAIT: begin
          lock = 1'b1;
          if (!wait_hold && frame_cnt == FRAME_LAST) next_state = S_MOVE1;
        end
        S_MOVE1: begin
          update_head = 1'b1;
          next_state  = S_MOVE2;
        end
        S_MOVE2: begin
          ld_head_into_prev = 1'b1;
          check_inc         = 1'b1;
          next_state        = S_MOVE3;
        end
        S_MOVE3: begin
          if (isDead) begin
            next_state = S_DEAD;
          end else begin
            rst_address = 1'b1;
            next_state  = S_SH_RD;
          end
        end
        S_SH_RD: next_state = S_SH1;
        S_SH1: begin
          ld_q_into_curr = 1'b1;
          next_state     = S_SH2;
        end
        S_SH2: begin
          ld_prev_into_q    = 1'b1;
          ld_curr_into_prev = 1'b1;
          if (at_end) begin
            next_state = S_TAIL;
          end else begin
            inc_address = 1'b1;
            next_state  = S_SH_RD;
          end
        end
        S_TAIL: begin
          if (grow) begin
            next_state = S_TAIL_ADV;
          end else begin
            draw_curr = 1'b1;
            if (cnt_status == 4'd15) next_state = S_TAIL_ADV;
          end
        end
        // Step past the old tail (one slot further when growing) before rewriting the sentinel.
        S_TAIL_ADV: begin
          inc_address = (mirror != ADDR_LAST);
          next_state  = grow ? S_TAIL_ADV2 : S_TAIL_CLR;
        end
        S_TAIL_ADV2: begin
          inc_address = (mirror != ADDR_LAST);
          next_state  = S_TAIL_CLR;
        end
        S_TAIL_CLR: begin
          reset_ram  = 1'b1;
          next_state = S_TAIL_END;
        end
        S_TAIL_END: begin
          rst_address = 1'b1;
          next_state  = S_DRAW_RD;
        end
        S_DEAD: begin
          game_over = 1'b1;
          if (start) next_state = S_CLR;
        end
        default: next_state = S_CLR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_CLR;
      run        <= 1'b0;
      mirror     <= '0;
      len        <= INIT_LEN_A;
      frame_cnt  <= '0;
      cnt_status <= '0;
      grow       <= 1'b0;
      dir        <= 3'b100;
    end else if (!run) begin
      run <= 1'b1;
    end else begin
      state <= next_state;
      if (rst_address) mirror <= '0;
      else if (inc_address) mirror <= mirror + 1'b1;
      if (state == S_DEAD && start) begin
        mirror <= '0;
        dir    <= 3'b100;
      end
      cnt_status <= (draw_q || food_en || draw_curr) ? cnt_status + 1'b1 : '0;
      if (state == S_WAIT) begin
        if (!wait_hold) begin
          frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + 1'b1;
          // Up/down share bit 2, as do left/right, so a reversal is a request with the same bit 2.
          if (req_vld && (req[2] != dir[2])) dir <= req;
        end
      end else begin
        frame_cnt <= '0;
      end
      if (state == S_MOVE2) grow <= inc_length;
      if (state == S_INIT_DONE) len <= INIT_LEN_A;
      if (state == S_TAIL_END) begin
        if (grow && len != ADDR_LAST) len <= len + 1'b1;
        grow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_snake_control.sv
// Scoreboard bench for snake_control: expected strobe bursts are queued by the stimulus and
// matched by a monitor that run-length encodes the DUT strobe pattern.
module tb_snake_control;

  localparam int unsigned FRAMES = 8;

  logic       clk = 1'b0;
  logic       rst, start, isDead, inc_length;
  logic [3:0] key_dir;
  logic       reset_ram, ld_q_def, ld_head, rst_address, inc_address;
  logic       draw_q, draw_curr, food_en, update_head, check_inc, lock;
  logic       ld_head_into_prev, ld_q_into_curr, ld_prev_into_q, ld_curr_into_prev;
  logic [3:0] cnt_status;
  logic [2:0] dir, colour;
  logic       game_over;
`ifdef SNAKE_PAUSE_EN
  logic       pause = 1'b0;
`endif

  snake_control #(.FRAME_CYCLES(FRAMES), .MAX_LEN(16), .INIT_LEN(4)) dut (
    .clk(clk), .rst(rst), .start(start), .key_dir(key_dir), .isDead(isDead),
    .inc_length(inc_length), .reset_ram(reset_ram), .ld_q_def(ld_q_def), .ld_head(ld_head),
    .rst_address(rst_address), .inc_address(inc_address), .draw_q(draw_q),
    .draw_curr(draw_curr), .food_en(food_en), .update_head(update_head),
    .check_inc(check_inc), .lock(lock), .ld_head_into_prev(ld_head_into_prev),
    .ld_q_into_curr(ld_q_into_curr), .ld_prev_into_q(ld_prev_into_q),
    .ld_curr_into_prev(ld_curr_into_prev), .cnt_status(cnt_status), .dir(dir),
    .colour(colour), .game_over(game_over)
`ifdef SNAKE_PAUSE_EN
    , .pause(pause)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [13:0] K_RR = 14'h2000, K_QDEF = 14'h1000, K_HEAD = 14'h0800;
  localparam logic [13:0] K_DQ = 14'h0400, K_DC = 14'h0200, K_FOOD = 14'h0100;
  localparam logic [13:0] K_UH = 14'h0080, K_CI = 14'h0040, K_LOCK = 14'h0020;
  localparam logic [13:0] K_HP = 14'h0010, K_QC = 14'h0008, K_PQ = 14'h0004;
  localparam logic [13:0] K_CP = 14'h0002, K_GO = 14'h0001;

  typedef struct {
    logic [13:0] cls;
    int unsigned len;
    logic [2:0]  col;
    logic [3:0]  cf;
    logic [3:0]  cl;
    logic [2:0]  dir;
  } rec_t;

  rec_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          mon_on = 1'b0;
  logic [13:0] cls_now;
  logic [14:0] strobes;
  logic [13:0] run_cls = '0;
  int unsigned run_len = 0;
  logic [3:0]  run_cf, run_cl;
  logic [2:0]  run_col, run_dir;
  int          rec_idx = 0;

  assign cls_now = {reset_ram, ld_q_def, ld_head, draw_q, draw_curr, food_en, update_head,
                    check_inc, lock, ld_head_into_prev, ld_q_into_curr, ld_prev_into_q,
                    ld_curr_into_prev, game_over};
  assign strobes = {reset_ram, ld_q_def, ld_head, rst_address, inc_address, draw_q, draw_curr,
                    food_en, update_head, check_inc, lock, ld_head_into_prev, ld_q_into_curr,
                    ld_prev_into_q, ld_curr_into_prev};

  task automatic emit();
    rec_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL rec%0d unexpected burst: got cls=%h len=%0d", rec_idx, run_cls, run_len);
    end else begin
      e = exp_q.pop_front();
      if (run_cls !== e.cls || (e.len != 0 && run_len != e.len) || run_col !== e.col ||
          run_cf !== e.cf || run_cl !== e.cl || run_dir !== e.dir) begin
        errors++;
        $display("FAIL rec%0d: got cls=%h len=%0d col=%b cnt=%0d..%0d dir=%b, need cls=%h len=%0d col=%b cnt=%0d..%0d dir=%b",
                 rec_idx, run_cls, run_len, run_col, run_cf, run_cl, run_dir,
                 e.cls, e.len, e.col, e.cf, e.cl, e.dir);
      end
    end
    rec_idx++;
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (cls_now !== run_cls) begin
        if (run_cls != '0) emit();
        run_cls = cls_now;
        run_len = 1;
        run_cf  = cnt_status;
      end else begin
        run_len++;
      end
      run_cl  = cnt_status;
      run_col = colour;
      run_dir = dir;
    end else begin
      run_cls = '0;
    end
  end

  task automatic push(input logic [13:0] c, input int unsigned n, input logic [2:0] col,
                      input logic [3:0] cf, input logic [3:0] cl, input logic [2:0] d);
    rec_t r;
    r.cls = c; r.len = n; r.col = col; r.cf = cf; r.cl = cl; r.dir = d;
    exp_q.push_back(r);
  endtask

  task automatic push_powerup();
    push(K_RR, 16, 3'b000, 4'd0, 4'd0, 3'b100);
    push(K_QDEF, 4, 3'b000, 4'd0, 4'd0, 3'b100);
    push(K_HEAD, 1, 3'b000, 4'd0, 4'd0, 3'b100);
  endtask

  // mode 0: full frame, 1: dies at MOVE cycle 3, 2: reset during the first shift step
  task automatic push_frame(input int unsigned L, input int unsigned wlen, input logic [2:0] d0,
                            input logic [2:0] d1, input bit g, input int mode);
    for (int unsigned i = 0; i < L; i++) push(K_DQ, 16, 3'b010, 4'd0, 4'd15, d0);
    push(K_FOOD, 16, 3'b100, 4'd0, 4'd15, d0);
    push(K_LOCK, wlen, 3'b000, 4'd0, 4'd0, d1);
    push(K_UH, 1, 3'b000, 4'd0, 4'd0, d1);
    push(K_HP | K_CI, 1, 3'b000, 4'd0, 4'd0, d1);
    if (mode == 1) begin
      push(K_GO, 3, 3'b000, 4'd0, 4'd0, d1);
    end else if (mode == 2) begin
      push(K_QC, 1, 3'b000, 4'd0, 4'd0, d1);
      push(K_PQ | K_CP, 1, 3'b000, 4'd0, 4'd0, d1);
    end else begin
      for (int unsigned i = 0; i <= L; i++) begin
        push(K_QC, 1, 3'b000, 4'd0, 4'd0, d1);
        push(K_PQ | K_CP, 1, 3'b000, 4'd0, 4'd0, d1);
      end
      if (!g) push(K_DC, 16, 3'b000, 4'd0, 4'd15, d1);
      push(K_RR, 1, 3'b000, 4'd0, 4'd0, d1);
    end
  endtask

  task automatic wait_sig(input int which, input string name);
    bit seen = 1'b0;
    logic s;
    for (int unsigned i = 0; i < 600 && !seen; i++) begin
      @(negedge clk);
      case (which)
        0: s = food_en;
        1: s = lock;
        2: s = check_inc;
        default: s = ld_prev_into_q;
      endcase
      if (s === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL wait_%s: got no pulse, need one within 600 cycles", name);
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (strobes !== 15'd0 || cnt_status !== 4'd0 || colour !== 3'b000 ||
        dir !== 3'b100 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL %s: got strobes=%h cnt=%0d colour=%b dir=%b go=%b, need 0/0/000/100/0",
               name, strobes, cnt_status, colour, dir, game_over);
    end
  endtask

  task automatic run_frame(input int unsigned L, input logic [3:0] keys, input bit g,
                           input int mode, input logic [2:0] d0, input logic [2:0] d1,
                           input int unsigned pcyc);
    push_frame(L, FRAMES + pcyc, d0, d1, g, mode);
    wait_sig(0, "food");
    key_dir = keys;
`ifdef SNAKE_PAUSE_EN
    if (pcyc > 0) begin
      wait_sig(1, "lock");
      repeat (2) @(negedge clk);
      pause = 1'b1;
      repeat (pcyc) @(negedge clk);
      pause = 1'b0;
    end
`endif
    if (mode == 2) begin
      wait_sig(3, "shift");
      key_dir = 4'b0000;
      rst = 1'b0;
      @(negedge clk);
      check_idle("reset_mid_shift");
      @(negedge clk);
      rst = 1'b1;
    end else begin
      wait_sig(2, "check_inc");
      key_dir    = 4'b0000;
      inc_length = g;
      isDead     = (mode == 1);
      @(negedge clk);
      inc_length = 1'b0;
      @(negedge clk);
      isDead = 1'b0;
      if (mode == 1) begin
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
  endtask

  initial begin
    bit drained = 1'b0;
    rst = 1'b0; start = 1'b0; isDead = 1'b0; inc_length = 1'b0; key_dir = 4'b0000;
    repeat (2) @(negedge clk);
    check_idle("reset_state");
    mon_on = 1'b1;
    push_powerup();
    rst = 1'b1;
`ifdef SNAKE_PAUSE_EN
    run_frame(4, 4'b0100, 1'b0, 0, 3'b100, 3'b100, 20);
`else
    run_frame(4, 4'b0100, 1'b0, 0, 3'b100, 3'b100, 0);
`endif
    run_frame(4, 4'b0001, 1'b1, 0, 3'b100, 3'b001, 0);
    run_frame(5, 4'b1011, 1'b0, 0, 3'b001, 3'b100, 0);
    run_frame(5, 4'b0010, 1'b0, 1, 3'b100, 3'b000, 0);
    push_powerup();
    run_frame(4, 4'b0000, 1'b0, 2, 3'b100, 3'b100, 0);
    push_powerup();
    run_frame(4, 4'b0000, 1'b0, 0, 3'b100, 3'b100, 0);
    for (int unsigned i = 0; i < 600 && !drained; i++) begin
      if (exp_q.size() == 0) drained = 1'b1;
      else @(negedge clk);
    end
    mon_on = 1'b0;
    while (exp_q.size() != 0) begin
      rec_t e;
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing burst: got none, need cls=%h len=%0d", e.cls, e.len);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/snake_control.md
Name: snake_control

Overview:
- Master sequencer for the snake game datapath: owns every datapath strobe, the 4-bit pixel sub-counter `cnt_status`, the move direction and the pixel colour.
- Runs power-up RAM clear and default-body load, then a per-frame loop: draw, wait, move/shift, grow check.
- Sits between the keyboard/key decode and the datapath; `plotEn/x/y` from the datapath plus `colour` from this block feed the VGA adapter.

Parameters:
- FRAME_CYCLES, 833333, clocks per game tick (60 Hz at 50 MHz).
- MAX_LEN, 2048, snake RAM depth; addresses 0..MAX_LEN-1.
- INIT_LEN, 4, segments written by default-body load.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-low reset; sampled on posedge clk only.
- start  in  1  level; leaves DEAD when high.
- key_dir  in  4  {up,down,left,right} level requests.
- isDead  in  1  datapath collision flag.
- inc_length  in  1  datapath food-eaten flag, valid while check_inc=1.
- reset_ram, ld_q_def, ld_head, rst_address, inc_address  out  1 each  datapath strobes.
- draw_q, draw_curr, food_en, update_head, check_inc, lock  out  1 each  datapath strobes.
- ld_head_into_prev, ld_q_into_curr, ld_prev_into_q, ld_curr_into_prev  out  1 each  datapath strobes.
- cnt_status  out  4  pixel index within a 4x4 cell.
- dir  out  3  movement code: 3'b100 up, 3'b110 down, 3'b000 left, 3'b001 right.
- colour  out  3  pixel colour.
- game_over  out  1  high in DEAD.

Behaviour:
- Reset: when rst=0 at posedge, state goes to CLR, and all strobes, cnt_status and address counter are cleared.
- Reset values: dir=3'b100, colour=0, game_over=0, grow=0. Reset mid-frame aborts immediately.
- Outputs are Moore, decoded from the registered state and counters.
- RAM latency: q is valid 2 edges after an address change. Every address step is followed by one RD_WAIT cycle before q is used.
- State CLR:
  - reset_ram=1 and inc_address=1 every cycle for MAX_LEN cycles (internal 11-bit mirror counter).
  - Then rst_address=1 for one cycle and go to INIT.
- State INIT:
  - ld_q_def=1 and inc_address=1 for INIT_LEN cycles.
  - Next cycle: ld_head=1, rst_address=1; go to DRAW_RD.
- State DRAW_RD: wait one cycle for q, then go to DRAW.
- State DRAW:
  - If q[15]=1 (sentinel) or mirror=MAX_LEN-1: go to FOOD.
  - Otherwise draw_q=1 and colour=3'b010 for 16 cycles, cnt_status 0..15.
  - Then inc_address=1 and go to DRAW_RD.
- State FOOD: rst_address=1; food_en=1 and colour=3'b100 for 16 cycles, cnt_status 0..15; go to WAIT.
- State WAIT:
  - Frame counter counts 0..FRAME_CYCLES-1, then go to MOVE.
  - lock=1 every WAIT cycle.
  - key_dir sampled each WAIT cycle: priority up>down>left>right. A request opposite to current dir is ignored. Zero keys keep dir.
- State MOVE:
  - Cycle 1: update_head=1.
  - Cycle 2: ld_head_into_prev=1 and check_inc=1; grow<=inc_length.
  - Cycle 3: if isDead=1, go to DEAD. Otherwise rst_address=1 and go to SH_RD.
- Shift loop (SH_RD, wait) -> SH1 -> SH2:
  - SH1: ld_q_into_curr=1.
  - SH2: ld_prev_into_q=1, ld_curr_into_prev=1.
  - If curr was sentinel, go to TAIL. Otherwise inc_address=1 and go to SH_RD.
  - If the mirror reaches MAX_LEN-1, force TAIL (length saturates; no wrap).
- State TAIL:
  - grow=0: draw_curr=1 with colour=0 for 16 cycles to erase the dropped tail. The sentinel slot is overwritten by the old tail, so a reset_ram=1 write is issued at the next address to restore the sentinel.
  - grow=1: no erase; reset_ram written one address further. Clear grow.
  - Go to DRAW (via rst_address).
- State DEAD:
  - game_over=1, all strobes 0.
  - start=1 goes to CLR, dir<=3'b100.
  - isDead checked only in MOVE and at the end of DRAW.
- Simultaneous events: rst dominates; isDead dominates grow; start is ignored outside DEAD.

Optional Feature:
- Macro SNAKE_PAUSE_EN.
- When defined: adds input `pause` (1 bit).
  - While pause=1 in WAIT, the frame counter holds and key_dir is ignored.
  - Pause in any other state takes effect on the next WAIT entry.
- When undefined: no port, and WAIT always counts.

Test Plan:
- Power-up, rst low 2 cycles, FRAME_CYCLES=8, MAX_LEN=16 -> reset_ram high exactly 16 cycles, then ld_q_def 4 cycles, ld_head 1 pulse, first draw_q burst 16 cycles with cnt_status 0..15.
- Steady frame, 4-segment snake -> 4 draw bursts, 1 food burst, 8 WAIT cycles, 1 update_head, 5 ld_prev_into_q pulses, 1 erase burst with colour=0.
- In WAIT, dir=up, assert key_dir=4'b0100 (down) -> dir stays 3'b100. Assert key_dir=4'b0001 -> dir=3'b001 on next MOVE.
- inc_length=1 during check_inc -> no draw_curr burst that frame; next frame draws 5 segments.
- isDead=1 at MOVE cycle 3 -> DEAD, game_over=1. start=1 -> CLR, dir=3'b100. rst low during shift loop -> CLR next cycle, all strobes 0.
- SNAKE_PAUSE_EN defined, pause=1 for 20 cycles mid-WAIT -> update_head delayed exactly 20 cycles.
